// File: rtl/prtc_host_seq.sv
// prtc_host_seq: host-side initiator for the C033 (DATA) / C034 (CTL) RTC+BRAM
// register protocol. Expands one host request (BRAM byte read/write, 32-bit
// clock read/write) into the DATA/CTL write, strobe and read-back sequence the
// prtc responder expects, and flushes the responder FSM after every reset.
module prtc_host_seq #(
   parameter int FLUSH_STROBES = 3,
   parameter int STEP_GAP      = 1
) (
   input  logic        CLK_14M,
   input  logic        reset,
   input  logic        cen,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic [7:0]  bram_addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        rtc_addr,
   output logic [7:0]  rtc_din,
   output logic        rtc_rw,
   output logic        rtc_strobe,
   input  logic [7:0]  rtc_dout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FLUSH = 3'd1;
   localparam logic [2:0] S_DWR   = 3'd2;
   localparam logic [2:0] S_CSET  = 3'd3;
   localparam logic [2:0] S_CSTB  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;
   localparam logic [2:0] S_RDA   = 3'd6;
   localparam logic [2:0] S_RDC   = 3'd7;

   // Unit kinds: W = DWR+CSET+CSTB+GAP, S = CSET+CSTB+GAP, R = RDA+RDC
   localparam logic [1:0] U_W = 2'd0;
   localparam logic [1:0] U_S = 2'd1;
   localparam logic [1:0] U_R = 2'd2;

   localparam logic [1:0] OP_BRD = 2'd0;
   localparam logic [1:0] OP_BWR = 2'd1;
   localparam logic [1:0] OP_CRD = 2'd2;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_STROBES - 1);
   localparam logic [2:0] GAP_LAST   = 3'(STEP_GAP - 1);

   // Unit k of byte group n for the given operation: {kind, rd, data byte}.
   function automatic logic [10:0] unit_dec(input logic fl, input logic [1:0] o,
                                            input logic [7:0] a, input logic [31:0] wd,
                                            input logic [1:0] k, input logic [1:0] n);
      logic [1:0] kind;
      logic       rd;
      logic [7:0] b;
      kind = U_W;
      rd   = 1'b0;
      b    = 8'h00;
      if (fl) begin
         // 0x00 matches no command; rd=1 turns any pending transfer into a read
         rd = 1'b1;
      end else begin
         case (o)
            OP_BRD: case (k)
               2'd0:    b = {1'b1, 4'b0111, a[7:5]};
               2'd1:    b = {1'b0, a[4:0], 2'b00};
               2'd2:    begin kind = U_S; rd = 1'b1; end
               default: kind = U_R;
            endcase
            OP_BWR: case (k)
               2'd0:    b = {1'b0, 4'b0111, a[7:5]};
               2'd1:    b = {1'b0, a[4:0], 2'b00};
               default: b = wd[7:0];
            endcase
            OP_CRD: case (k)
               2'd0:    b = {1'b1, 3'b000, n, 2'b01};
               2'd1:    begin kind = U_S; rd = 1'b1; end
               default: kind = U_R;
            endcase
            default: b = (k == 2'd0) ? {1'b0, 3'b000, n, 2'b01} : wd[8*n +: 8];
         endcase
      end
      return {kind, rd, b};
   endfunction

   // Index of the last unit inside one byte group.
   function automatic logic [1:0] last_k(input logic fl, input logic [1:0] o);
      if (fl) return 2'd0;
      case (o)
         OP_BRD:  return 2'd3;
         OP_BWR:  return 2'd2;
         OP_CRD:  return 2'd2;
         default: return 2'd1;
      endcase
   endfunction

   // Index of the last byte group (clock ops walk bytes 0..3).
   function automatic logic [2:0] last_n(input logic fl, input logic [1:0] o);
      if (fl) return FLUSH_LAST;
      return o[1] ? 3'd3 : 3'd0;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [1:0]  k_q, k_d, k_nx;
   logic [2:0]  n_q, n_d, n_nx;
   logic [2:0]  gap_q, gap_d;
   logic        flush_q, flush_d;
   logic        rd_q, rd_d;
   logic [1:0]  op_q, op_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rtc_addr_q, rtc_addr_d;
   logic [7:0]  rtc_din_q, rtc_din_d;
   logic        rtc_rw_q, rtc_rw_d;
   logic        adv, start;
   logic [10:0] u;

   // Next-state: step through primitive steps, advance units/byte groups, accept requests.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      n_d        = n_q;
      gap_d      = gap_q;
      flush_d    = flush_q;
      rd_d       = rd_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rdata_d    = rdata_q;
      rtc_addr_d = rtc_addr_q;
      rtc_din_d  = rtc_din_q;
      rtc_rw_d   = rtc_rw_q;
      adv        = 1'b0;
      start      = 1'b0;
      k_nx       = k_q;
      n_nx       = n_q;
      u          = '0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d    = op;
               addr_d  = bram_addr;
               wdata_d = wdata;
               rdata_d = '0;
               flush_d = 1'b0;
               busy_d  = 1'b1;
               k_nx    = 2'd0;
               n_nx    = 3'd0;
               start   = 1'b1;
            end
         end
         S_FLUSH: begin
            flush_d = 1'b1;
            k_nx    = 2'd0;
            n_nx    = 3'd0;
            start   = 1'b1;
         end
         S_DWR: begin
            state_d    = S_CSET;
            rtc_addr_d = 1'b1;
            rtc_rw_d   = 1'b0;
            rtc_din_d  = {1'b1, rd_q, 6'b0};
         end
         S_CSET: state_d = S_CSTB;
         S_CSTB: begin
            // strobe fires combinationally in the cen cycle; leave right after it
            if (cen) begin
               state_d  = S_GAP;
               rtc_rw_d = 1'b1;
               gap_d    = GAP_LAST;
            end
         end
         S_GAP: begin
            if (gap_q == 3'd0) adv = 1'b1;
            else               gap_d = gap_q - 3'd1;
         end
         S_RDA: state_d = S_RDC;
         default: begin
            rdata_d[8*n_q[1:0] +: 8] = rtc_dout;
            adv = 1'b1;
         end
      endcase

      if (adv) begin
         if (k_q == last_k(flush_q, op_q)) begin
            if (n_q == last_n(flush_q, op_q)) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = ~flush_q;
               rtc_addr_d = 1'b0;
               rtc_rw_d   = 1'b1;
            end else begin
               k_nx  = 2'd0;
               n_nx  = n_q + 3'd1;
               start = 1'b1;
            end
         end else begin
            k_nx  = k_q + 2'd1;
            start = 1'b1;
         end
      end

      if (start) begin
         u    = unit_dec(flush_d, op_d, addr_d, wdata_d, k_nx, n_nx[1:0]);
         k_d  = k_nx;
         n_d  = n_nx;
         rd_d = u[8];
         case (u[10:9])
            U_W: begin
               state_d    = S_DWR;
               rtc_addr_d = 1'b0;
               rtc_rw_d   = 1'b0;
               rtc_din_d  = u[7:0];
            end
            U_S: begin
               state_d    = S_CSET;
               rtc_addr_d = 1'b1;
               rtc_rw_d   = 1'b0;
               rtc_din_d  = {1'b1, u[8], 6'b0};
            end
            default: begin
               state_d    = S_RDA;
               rtc_addr_d = 1'b0;
               rtc_rw_d   = 1'b1;
            end
         endcase
      end
   end

   // State and output registers; reset discards any latched request and reruns the flush.
   always_ff @(posedge CLK_14M or posedge reset) begin
      if (reset) begin
         state_q    <= S_FLUSH;
         k_q        <= 2'd0;
         n_q        <= 3'd0;
         gap_q      <= 3'd0;
         flush_q    <= 1'b1;
         rd_q       <= 1'b0;
         op_q       <= 2'd0;
         addr_q     <= 8'h00;
         wdata_q    <= 32'h0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         rdata_q    <= 32'h0;
         rtc_addr_q <= 1'b0;
         rtc_din_q  <= 8'h00;
         rtc_rw_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         n_q        <= n_d;
         gap_q      <= gap_d;
         flush_q    <= flush_d;
         rd_q       <= rd_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         rtc_addr_q <= rtc_addr_d;
         rtc_din_q  <= rtc_din_d;
         rtc_rw_q   <= rtc_rw_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign rtc_addr   = rtc_addr_q;
   assign rtc_din    = rtc_din_q;
   assign rtc_rw     = rtc_rw_q;
   assign rtc_strobe = (state_q == S_CSTB) & cen;

endmodule

// File: tb/tb_prtc_host_seq.sv
// tb_prtc_host_seq: drives prtc_host_seq against a behavioural prtc responder
// (BRAM 0x5F=0x81, 0x03=0x01, clock=0x0600_0000) and scoreboards each done.
module tb_prtc_host_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cen = 1'b1;
   logic        req = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [7:0]  bram_addr = 8'h00;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, rtc_addr, rtc_rw, rtc_strobe;
   logic [31:0] rdata;
   logic [7:0]  rtc_din;
   logic [7:0]  rtc_dout = 8'h00;

   always #5 clk = ~clk;

   prtc_host_seq #(.FLUSH_STROBES(3), .STEP_GAP(1)) dut (
      .CLK_14M(clk), .reset(reset), .cen(cen), .req(req), .op(op),
      .bram_addr(bram_addr), .wdata(wdata), .busy(busy), .done(done),
      .rdata(rdata), .rtc_addr(rtc_addr), .rtc_din(rtc_din), .rtc_rw(rtc_rw),
      .rtc_strobe(rtc_strobe), .rtc_dout(rtc_dout));

   // ---------------- responder model ----------------
   localparam int R_IDLE = 0, R_WAIT = 1, R_PRAM = 2, R_CLOCK = 3;
   logic [7:0]  bram [0:255];
   logic [31:0] clkv;
   logic [7:0]  data_r, ctl_r, paddr;
   logic [2:0]  hi;
   logic [1:0]  cn;
   int          rs;

   initial begin
      for (int i = 0; i < 256; i++) bram[i] = 8'h00;
      bram[8'h5F] = 8'h81;
      bram[8'h03] = 8'h01;
      clkv   = 32'h0600_0000;
      data_r = 8'h00;
      ctl_r  = 8'h00;
      paddr  = 8'h00;
      hi     = 3'd0;
      cn     = 2'd0;
      rs     = R_IDLE;
   end

   always @(posedge clk) begin
      if (!rtc_rw) begin
         if (rtc_addr) ctl_r <= rtc_din;
         else          data_r <= rtc_din;
      end
      rtc_dout <= rtc_addr ? ctl_r : data_r;
      if (rtc_strobe) begin
         case (rs)
            R_IDLE: begin
               if (data_r[6:3] == 4'b0111) begin
                  hi <= data_r[2:0];
                  rs <= R_WAIT;
               end else if (data_r[6:4] == 3'b000 && data_r[1:0] == 2'b01) begin
                  cn <= data_r[3:2];
                  rs <= R_CLOCK;
               end
            end
            R_WAIT: begin
               paddr <= {hi, data_r[6:2]};
               rs    <= R_PRAM;
            end
            R_PRAM: begin
               if (ctl_r[6]) data_r <= bram[paddr];
               else          bram[paddr] <= data_r;
               rs <= R_IDLE;
            end
            default: begin
               if (ctl_r[6]) data_r <= clkv[8*cn +: 8];
               else          clkv[8*cn +: 8] <= data_r;
               rs <= R_IDLE;
            end
         endcase
      end
   end

   // ---------------- cen pattern: high 1 cycle in cen_div ----------------
   int cen_div = 1;
   int cen_ph  = 0;
   always @(posedge clk) begin
      #1;
      cen_ph = (cen_ph + 1) % cen_div;
      cen    = (cen_ph == 0);
   end

   // ---------------- scoreboard + monitor ----------------
   typedef struct {
      logic [31:0] rd;
      int          bcyc;
   } exp_t;
   exp_t expq[$];
   exp_t mon_e;
   int   checks = 0, failures = 0;
   int   strobe_cnt = 0, done_cnt = 0, busy_cnt = 0;
   logic strobe_prev = 1'b0;

   always @(negedge clk) begin
      if (rtc_strobe) begin
         strobe_cnt++;
         checks++;
         if (!(cen === 1'b1 && rtc_rw === 1'b0 && rtc_addr === 1'b1 && strobe_prev === 1'b0)) begin
            failures++;
            $display("FAIL strobe_shape actual cen=%b rw=%b addr=%b prev=%b required cen=1 rw=0 addr=1 prev=0",
                     cen, rtc_rw, rtc_addr, strobe_prev);
         end
      end
      strobe_prev = rtc_strobe;
      if (done === 1'b1) begin
         done_cnt++;
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected actual=done required=no_done");
         end else begin
            mon_e = expq.pop_front();
            if (rdata !== mon_e.rd) begin
               failures++;
               $display("FAIL rdata actual=%h required=%h", rdata, mon_e.rd);
            end
            if (mon_e.bcyc != 0) begin
               checks++;
               if (busy_cnt != mon_e.bcyc) begin
                  failures++;
                  $display("FAIL busy_cycles actual=%0d required=%0d", busy_cnt, mon_e.bcyc);
               end
            end
         end
      end
      if (busy === 1'b1) busy_cnt++;
      else               busy_cnt = 0;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp_v);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},   {31'd0, busy},       32'd1);
      chk({tag, "_done"},   {31'd0, done},       32'd0);
      chk({tag, "_rdata"},  rdata,               32'd0);
      chk({tag, "_addr"},   {31'd0, rtc_addr},   32'd0);
      chk({tag, "_din"},    {24'd0, rtc_din},    32'd0);
      chk({tag, "_rw"},     {31'd0, rtc_rw},     32'd1);
      chk({tag, "_strobe"}, {31'd0, rtc_strobe}, 32'd0);
   endtask

   task automatic wait_not_busy(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual busy=%b required busy=0", name, busy);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (expq.size() != 0 && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (expq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual pending=%0d required pending=0", name, expq.size());
         expq.delete();
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input int eb, input bit push);
      exp_t e;
      wait_not_busy("issue");
      if (push) begin
         e.rd   = er;
         e.bcyc = eb;
         expq.push_back(e);
      end
      op        = o;
      bram_addr = a;
      wdata     = wd;
      req       = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int s0, d0, n;
   initial begin
      // 1: reset values, flush, first BRAM read
      #1 reset = 1'b1;
      #1 chk_reset_vals("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      s0 = strobe_cnt;
      d0 = done_cnt;
      wait_not_busy("flush");
      chk("flush_strobes", 32'(strobe_cnt - s0), 32'd3);
      chk("flush_no_done", 32'(done_cnt - d0), 32'd0);
      issue(2'd0, 8'h5F, 32'h0, 32'h0000_0081, 13, 1'b1);
      drain("t1");

      // 2: BRAM write then read back, neighbour untouched
      issue(2'd1, 8'h40, 32'h0000_00A5, 32'h0, 12, 1'b1);
      issue(2'd0, 8'h40, 32'h0, 32'h0000_00A5, 13, 1'b1);
      issue(2'd0, 8'h41, 32'h0, 32'h0, 13, 1'b1);
      drain("t2");

      // 3: clock read, write, read back
      issue(2'd2, 8'h00, 32'h0, 32'h0600_0000, 36, 1'b1);
      issue(2'd3, 8'h00, 32'h1234_5678, 32'h0, 32, 1'b1);
      issue(2'd2, 8'h00, 32'h0, 32'h1234_5678, 36, 1'b1);
      drain("t3");

      // 4: sparse cen
      cen_div = 4;
      issue(2'd0, 8'h03, 32'h0, 32'h0000_0001, 0, 1'b1);
      drain("t4");
      cen_div = 1;

      // 5: reset while responder sits in WAIT
      issue(2'd0, 8'h03, 32'h0, 32'h0, 0, 1'b0);
      n = 0;
      while (rtc_strobe !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t5_first_strobe_seen", {31'd0, rtc_strobe}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_vals("midreset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      s0 = strobe_cnt;
      wait_not_busy("reflush");
      chk("reflush_strobes", 32'(strobe_cnt - s0), 32'd3);
      issue(2'd0, 8'h03, 32'h0, 32'h0000_0001, 13, 1'b1);
      drain("t5");

      // 6a: req during busy is ignored
      d0 = done_cnt;
      issue(2'd0, 8'h5F, 32'h0, 32'h0000_0081, 13, 1'b1);
      repeat (3) @(negedge clk);
      op = 2'd1; bram_addr = 8'h5F; wdata = 32'h0000_00FF; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      drain("t6a");
      repeat (20) @(negedge clk);
      chk("ignored_req_one_done", 32'(done_cnt - d0), 32'd1);
      issue(2'd0, 8'h5F, 32'h0, 32'h0000_0081, 13, 1'b1);
      drain("t6a_verify");

      // 6b: req held high -> back-to-back ops
      wait_not_busy("t6b");
      for (int i = 0; i < 3; i++) expq.push_back('{32'h0000_00A5, 13});
      d0 = done_cnt;
      op = 2'd0; bram_addr = 8'h40; req = 1'b1;
      n = 0;
      while ((done_cnt - d0) < 3 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      req = 1'b0;
      chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
      repeat (30) @(negedge clk);
      chk("b2b_no_extra", 32'(done_cnt - d0), 32'd3);
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      drain("t6b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
